// File: rtl/quantser_sched_pkg.sv
// Shared types and width constants for the quantizer/serializer scheduler.
package quantser_sched_pkg;

  localparam int BWOUT   = 32;
  localparam int BWBWOUT = $clog2(BWOUT);
  localparam int NVEC_W  = 16;
  localparam int ADDR_W  = 9;

  typedef enum logic [1:0] {
    QS_IDLE,
    QS_WAIT_ACC,
    QS_SERIAL,
    QS_DONE
  } qs_state_t;

endpackage

// File: rtl/quantser_sched_if.sv
// Job configuration, accumulator handshake and serializer/output-RAM controls.
interface quantser_sched_if #(
  parameter int BWBWOUT = quantser_sched_pkg::BWBWOUT,
  parameter int NVEC_W  = quantser_sched_pkg::NVEC_W,
  parameter int ADDR_W  = quantser_sched_pkg::ADDR_W
);
  logic [BWBWOUT-1:0] cfg_bwout;
  logic [NVEC_W-1:0]  cfg_nvec;
  logic [ADDR_W-1:0]  cfg_baddr;
  logic [ADDR_W-1:0]  cfg_stride;
  logic               go;
  logic               acc_valid;
  logic               stall;
  logic               acc_ack;
  logic               load;
  logic               step;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               busy;
  logic               done;

  modport master (
    output cfg_bwout, cfg_nvec, cfg_baddr, cfg_stride, go, acc_valid, stall,
    input  acc_ack, load, step, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  cfg_bwout, cfg_nvec, cfg_baddr, cfg_stride, go, acc_valid, stall,
    output acc_ack, load, step, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/quantser_sched_addrgen.sv
// Output-memory address generator: per-vector base plus a running bit-plane address.
module quantser_addrgen #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              init,
  input  logic              bit_adv,
  input  logic              vec_adv,
  input  logic              hold,
  input  logic [ADDR_W-1:0] baddr,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] vbase;
  logic [ADDR_W-1:0] stride_r;
  logic [ADDR_W-1:0] vbase_nxt;

  assign vbase_nxt = vbase + stride_r;

  // vec_adv wins over bit_adv on the last bit so addr jumps straight to the next base
  always_ff @(posedge clk) begin
    if (clr) begin
      vbase    <= '0;
      addr     <= '0;
      stride_r <= '0;
    end else if (!hold) begin
      if (init) begin
        vbase    <= baddr;
        addr     <= baddr;
        stride_r <= stride;
      end else if (vec_adv) begin
        vbase <= vbase_nxt;
        addr  <= vbase_nxt;
      end else if (bit_adv) begin
        addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/quantser_sched.sv
// Scheduler FSM: per vector waits for the accumulator, loads the serializer, then steps one bit plane per cycle.
module quantser_sched #(
  parameter int BWOUT   = 32,
  parameter int BWBWOUT = $clog2(BWOUT),
  parameter int NVEC_W  = 16,
  parameter int ADDR_W  = 9
) (
  input logic             clk,
  input logic             clr,
  quantser_sched_if.slave bus
);
  import quantser_sched_pkg::*;

  qs_state_t          state, state_nxt;
  logic [BWBWOUT-1:0] bwout_r;
  logic [BWBWOUT-1:0] bitcnt;
  logic [NVEC_W-1:0]  vrem;
  logic               init, bit_adv, vec_adv;
  logic [ADDR_W-1:0]  addr;

  quantser_addrgen #(.ADDR_W(ADDR_W)) u_addrgen (
    .clk     (clk),
    .clr     (clr),
    .init    (init),
    .bit_adv (bit_adv),
    .vec_adv (vec_adv),
    .hold    (bus.stall),
    .baddr   (bus.cfg_baddr),
    .stride  (bus.cfg_stride),
    .addr    (addr)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= QS_IDLE;
      bwout_r <= '0;
      bitcnt  <= '0;
      vrem    <= '0;
    end else if (!bus.stall) begin
      state <= state_nxt;
      if (init) begin
        bwout_r <= bus.cfg_bwout;
        vrem    <= bus.cfg_nvec;
      end
      if (bus.load) begin
        vrem   <= vrem - 1'b1;
        bitcnt <= bwout_r;
      end
      if (bus.step) begin
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end

  // vrem is decremented at load, so the bwout=0 path tests it before the decrement lands
  always_comb begin
    state_nxt   = state;
    init        = 1'b0;
    bit_adv     = 1'b0;
    vec_adv     = 1'b0;
    bus.load    = 1'b0;
    bus.acc_ack = 1'b0;
    bus.step    = 1'b0;
    bus.wr_en   = 1'b0;
    if (!bus.stall) begin
      case (state)
        QS_IDLE: begin
          if (bus.go) begin
            init      = 1'b1;
            state_nxt = (bus.cfg_nvec != '0) ? QS_WAIT_ACC : QS_DONE;
          end
        end
        QS_WAIT_ACC: begin
          if (bus.acc_valid) begin
            bus.load    = 1'b1;
            bus.acc_ack = 1'b1;
            if (bwout_r != '0) begin
              state_nxt = QS_SERIAL;
            end else begin
              vec_adv   = 1'b1;
              state_nxt = (vrem != NVEC_W'(1)) ? QS_WAIT_ACC : QS_DONE;
            end
          end
        end
        QS_SERIAL: begin
          bus.step  = 1'b1;
          bus.wr_en = 1'b1;
          bit_adv   = 1'b1;
          if (bitcnt == BWBWOUT'(1)) begin
            vec_adv   = 1'b1;
            state_nxt = (vrem != '0) ? QS_WAIT_ACC : QS_DONE;
          end
        end
        QS_DONE: begin
          state_nxt = QS_IDLE;
        end
        default: begin
          state_nxt = QS_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state != QS_IDLE);
  assign bus.done    = (state == QS_DONE);
  assign bus.wr_addr = addr;
endmodule

// File: tb/tb_quantser_sched.sv
// Scoreboard bench for quantser_sched: expected write addresses are queued by stimulus and popped by a monitor.
module tb_quantser_sched;
  import quantser_sched_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  quantser_sched_if bus ();

  quantser_sched dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int goCyc = 0;
  int loadCnt = 0, stepCnt = 0, wrCnt = 0, doneCnt = 0;
  int lastWrCyc = -1, doneCyc = -1;
  int loadCycs[$];
  logic [ADDR_W-1:0] wrq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every write and tracks handshake events
  always @(negedge clk) begin
    if (!clr) begin
      if (bus.stall)
        checkOutput("stall_quiet", int'({bus.load, bus.acc_ack, bus.step, bus.wr_en}), 0);
      if (bus.load) begin
        loadCnt++;
        loadCycs.push_back(cyc);
        checkOutput("load_ack", int'(bus.acc_ack), 1);
        checkOutput("load_step_excl", int'(bus.step), 0);
      end
      if (bus.step) stepCnt++;
      if (bus.wr_en) begin
        wrCnt++;
        lastWrCyc = cyc;
        tests++;
        if (wrq.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_wr: got write to %0d, expected no write", bus.wr_addr);
        end else begin
          tests--;
          checkOutput("wr_addr", int'(bus.wr_addr), int'(wrq.pop_front()));
        end
      end
      if (bus.done) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushJob(input int bw, input int nv, input int ba, input int st);
    for (int v = 0; v < nv; v++)
      for (int b = 0; b < bw; b++)
        wrq.push_back(ADDR_W'(ba + v * st + b));
  endtask

  // Pulses go for one cycle, then scrambles the config to prove it was latched
  task automatic applyStimulus(input int bw, input int nv, input int ba, input int st);
    bus.cfg_bwout  = BWBWOUT'(bw);
    bus.cfg_nvec   = NVEC_W'(nv);
    bus.cfg_baddr  = ADDR_W'(ba);
    bus.cfg_stride = ADDR_W'(st);
    bus.go = 1'b1;
    goCyc = cyc;
    tick();
    bus.go         = 1'b0;
    bus.cfg_bwout  = BWBWOUT'(7);
    bus.cfg_nvec   = NVEC_W'(3);
    bus.cfg_baddr  = ADDR_W'(85);
    bus.cfg_stride = ADDR_W'(51);
  endtask

  task automatic waitDone(input int limit, input string name);
    int start;
    bit seen;
    start = doneCnt;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (doneCnt > start) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no done in %0d cycles, expected done", name, limit);
    end else begin
      checkOutput({name, "_busy_drop"}, int'(bus.busy), 0);
      checkOutput({name, "_sb_empty"}, wrq.size(), 0);
    end
  endtask

  initial begin
    int l0, s0, w0, d0;
    clr = 1'b1;
    bus.go = 1'b0;
    bus.acc_valid = 1'b1;
    bus.stall = 1'b0;
    bus.cfg_bwout = '0;
    bus.cfg_nvec = '0;
    bus.cfg_baddr = '0;
    bus.cfg_stride = '0;
    tick();
    tick();
    checkOutput("rst_outputs", int'({bus.acc_ack, bus.load, bus.step, bus.wr_en, bus.busy, bus.done}), 0);
    checkOutput("rst_wr_addr", int'(bus.wr_addr), 0);
    clr = 1'b0;
    tick();

    // Two vectors of four bit planes with acc_valid held high
    loadCycs.delete();
    pushJob(4, 2, 10, 8);
    applyStimulus(4, 2, 10, 8);
    waitDone(60, "t1");
    checkOutput("t1_nloads", loadCycs.size(), 2);
    checkOutput("t1_load0", loadCycs.size() > 0 ? loadCycs[0] : -1, goCyc + 1);
    checkOutput("t1_load1", loadCycs.size() > 1 ? loadCycs[1] : -1, goCyc + 6);
    checkOutput("t1_done_after_wr", doneCyc, lastWrCyc + 1);
    checkOutput("t1_done_cyc", doneCyc, goCyc + 11);
    tick();

    // Empty job goes straight to DONE
    l0 = loadCnt; s0 = stepCnt; w0 = wrCnt;
    applyStimulus(4, 0, 50, 1);
    waitDone(10, "t2");
    checkOutput("t2_done_cyc", doneCyc, goCyc + 1);
    checkOutput("t2_no_activity", (loadCnt - l0) + (stepCnt - s0) + (wrCnt - w0), 0);

    // Two-cycle stall after the second write
    w0 = wrCnt;
    pushJob(3, 1, 40, 5);
    applyStimulus(3, 1, 40, 5);
    tick();
    tick();
    tick();
    bus.stall = 1'b1;
    checkOutput("t3_stall_addr0", int'(bus.wr_addr), 42);
    tick();
    checkOutput("t3_stall_addr1", int'(bus.wr_addr), 42);
    checkOutput("t3_stall_busy", int'(bus.busy), 1);
    tick();
    bus.stall = 1'b0;
    waitDone(20, "t3");
    checkOutput("t3_nwrites", wrCnt - w0, 3);
    checkOutput("t3_done_cyc", doneCyc, goCyc + 7);

    // acc_valid low for five WAIT_ACC cycles
    loadCycs.delete();
    bus.acc_valid = 1'b0;
    pushJob(2, 1, 100, 0);
    applyStimulus(2, 1, 100, 0);
    repeat (5) tick();
    checkOutput("t4_no_early_load", loadCycs.size(), 0);
    bus.acc_valid = 1'b1;
    waitDone(20, "t4");
    checkOutput("t4_load_cyc", loadCycs.size() > 0 ? loadCycs[0] : -1, goCyc + 6);
    checkOutput("t4_done_cyc", doneCyc, goCyc + 9);

    // Address wrap at the top of the 9-bit space
    pushJob(4, 1, 510, 0);
    applyStimulus(4, 1, 510, 0);
    waitDone(20, "t5");

    // Zero bit planes: loads happen, nothing is written
    l0 = loadCnt; w0 = wrCnt;
    applyStimulus(0, 2, 60, 4);
    waitDone(20, "t6");
    checkOutput("t6_nloads", loadCnt - l0, 2);
    checkOutput("t6_nwrites", wrCnt - w0, 0);
    checkOutput("t6_done_cyc", doneCyc, goCyc + 3);

    // clr mid-SERIAL aborts without a done pulse
    wrq.push_back(ADDR_W'(200));
    wrq.push_back(ADDR_W'(201));
    applyStimulus(8, 2, 200, 4);
    tick();
    tick();
    tick();
    clr = 1'b1;
    d0 = doneCnt;
    tick();
    clr = 1'b0;
    checkOutput("t7_clr_outputs", int'({bus.acc_ack, bus.load, bus.step, bus.wr_en, bus.busy, bus.done}), 0);
    checkOutput("t7_clr_wr_addr", int'(bus.wr_addr), 0);
    checkOutput("t7_sb_empty", wrq.size(), 0);
    repeat (3) tick();
    checkOutput("t7_no_done", doneCnt - d0, 0);
    pushJob(2, 1, 300, 1);
    applyStimulus(2, 1, 300, 1);
    waitDone(20, "t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
